// File: rtl/seq_div_ctrl.sv
// Iterative unsigned restoring divider: one shared subtractor, one quotient bit per clock,
// start/ready/done handshake. Results and div_by_zero are held until the next completion.
module seq_div_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  d_q;
  // Stored remainder is always < D, so WIDTH bits suffice; only the shifted value needs WIDTH+1.
  logic [WIDTH-1:0]  r_q;
  logic [CntW-1:0]   cnt_q;
  logic              dz_q;

  logic [WIDTH:0]    rs;
  logic [WIDTH+1:0]  sum;
  logic              no_borrow;

  // Shared subtractor: Rs - D as Rs + ~{0,D} + 1; carry-out set means Rs >= D.
  always_comb begin
    rs        = {r_q, q_q[WIDTH-1]};
    sum       = {1'b0, rs} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    // Without a borrow the difference is < D, so its top bit is necessarily clear.
    no_borrow = sum[WIDTH+1] & ~sum[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!ready) begin
            // Cycle following the done pulse: reopen for requests.
            ready <= 1'b1;
          end else if (start) begin
            q_q     <= dividend;
            d_q     <= divisor;
            r_q     <= '0;
            cnt_q   <= CntW'(WIDTH - 1);
            dz_q    <= (divisor == '0);
            ready   <= 1'b0;
            state_q <= (divisor == '0) ? StDone : StCalc;
          end
        end
        StCalc: begin
          r_q   <= no_borrow ? sum[WIDTH-1:0] : rs[WIDTH-1:0];
          q_q   <= {q_q[WIDTH-2:0], no_borrow};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          done <= 1'b1;
          if (dz_q) begin
            // Q still holds the untouched dividend on the divide-by-zero path.
            quotient    <= '1;
            remainder   <= q_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_q;
            remainder   <= r_q;
            div_by_zero <= 1'b0;
          end
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Scoreboard bench for seq_div_ctrl: driver pushes expected results from an arithmetic
// reference model, a negedge monitor pops and compares on every done pulse.
module tb_seq_div_ctrl;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_div_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dz;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_run = 0;
  int   last_q = 0;
  int   last_r = 0;
  int   last_dz = 0;
  bit   armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard, and holds outputs stable otherwise.
  always @(negedge clk) begin
    if (armed) begin
      if (done) begin
        check("done_width", done_run + 1, 1);
        check("ready_in_done", int'(ready), 0);
        check("pending_on_done", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", int'(quotient), e.q);
          check("remainder", int'(remainder), e.r);
          check("div_by_zero", int'(div_by_zero), e.dz);
          check("latency", cyc, e.due);
          last_q  = e.q;
          last_r  = e.r;
          last_dz = e.dz;
        end
      end else begin
        check("hold_quotient", int'(quotient), last_q);
        check("hold_remainder", int'(remainder), last_r);
        check("hold_div_by_zero", int'(div_by_zero), last_dz);
      end
    end
    done_run = done ? done_run + 1 : 0;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready, issue one request, and record what the reference model predicts.
  task automatic issue(input int a, input int b);
    int   n = 0;
    exp_t e;
    while (!ready && n < 200) begin
      next_cycle();
      n++;
    end
    check("ready_timeout", int'(ready), 1);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    next_cycle();
    e.q   = (b == 0) ? MAXV : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dz  = (b == 0) ? 1 : 0;
    e.due = cyc + ((b == 0) ? 1 : W + 1);
    sb.push_back(e);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sb.delete();
    last_q  = 0;
    last_r  = 0;
    last_dz = 0;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_div_by_zero", int'(div_by_zero), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      next_cycle();
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (3) next_cycle();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    armed = 1'b1;

    // Directed cases and bounds.
    issue(13, 3);
    issue(15, 1);
    issue(5, 7);
    issue(15, 15);
    issue(9, 0);
    drain();

    // Start while busy must be ignored.
    issue(12, 5);
    next_cycle();
    start    = 1'b1;
    dividend = 4'd1;
    divisor  = 4'd1;
    next_cycle();
    start = 1'b0;
    drain();

    // Reset during the second CALC cycle aborts with no done pulse.
    issue(14, 3);
    next_cycle();
    do_reset();
    repeat (8) next_cycle();
    issue(14, 3);
    drain();

    // All operand pairs back to back.
    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 0; b <= MAXV; b++) begin
        issue(a, b);
      end
    end
    drain();

    // Random operands, random idle gaps and stray starts while busy.
    repeat (200) begin
      int a;
      int b;
      a = $urandom_range(MAXV);
      b = $urandom_range(MAXV);
      repeat ($urandom_range(3)) next_cycle();
      issue(a, b);
      if ($urandom_range(1) == 1) begin
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        next_cycle();
        start = 1'b0;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
